// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the 32-bit UART link (uart_tx_32 / uart_rx_32_deser).
//   - UART_OVERSAMPLE : default clken ticks per serial bit
//   - UART_WORD_BYTES : bytes per link word
//   - uart_rx_state_e : receiver FSM state encoding
//   - lane_select     : extract byte lane idx from a 32-bit word
//   - lane_write      : replace byte lane idx of a 32-bit word
//   Byte lanes are little-endian: lane 0 is bits [7:0] and travels first.
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned UART_OVERSAMPLE = 16;
   localparam int unsigned UART_WORD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } uart_rx_state_e;

   function automatic logic [7:0] lane_select(input logic [31:0] word,
                                              input logic [1:0]  idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] lane_write(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  lane);
      logic [31:0] w;
      w = word;
      w[{idx, 3'b000} +: 8] = lane;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// uart_rx_sync_2ff
//   Two-flop synchroniser for a single asynchronous input bit.
//   Both flops reset to RESET_VAL (async, active-low).
//   Ports:
//     clk   in  system clock
//     rstn  in  async active-low reset
//     d     in  asynchronous input
//     q     out synchronised output (2 clk latency)
// ---------------------------------------------------------------------------
module uart_rx_sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_32_deser.sv
// ---------------------------------------------------------------------------
// uart_rx_32_deser
//   UART 8N1 receiver that assembles four bytes (lane 0 first) into one
//   32-bit word. All sampling uses the synchronised line; all counters
//   advance only on clken (OVERSAMPLE ticks per bit, sampled mid-bit).
//   Ports:
//     clk          in   system clock
//     rstn         in   async active-low reset
//     clken        in   oversample tick
//     rx           in   serial input, idle high, asynchronous
//     data_out     out  last complete word, updated only with data_valid
//     data_valid   out  1-cycle pulse when data_out updates
//     frame_err    out  1-cycle pulse when a stop bit is sampled low
//     timeout_err  out  1-cycle pulse when a partial word is dropped
//     rx_busy      out  byte in flight or partial word pending
//   Build option:
//     UART_RX_TIMEOUT_EN  when defined, a partial word idle for
//                         TIMEOUT_BITS bit-times is dropped with
//                         timeout_err; otherwise it waits indefinitely
//                         and timeout_err stays 0.
// ---------------------------------------------------------------------------
module uart_rx_32_deser
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned OVERSAMPLE   = UART_OVERSAMPLE,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clken,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic                  timeout_err,
   output logic                  rx_busy
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

   if (DATA_WIDTH != 32 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
       TIMEOUT_BITS == 0) begin : g_bad_cfg
      $error("uart_rx_32_deser: unsupported parameter set");
   end

   logic           rx_s;
   uart_rx_state_e state;
   logic [TW-1:0]  tick_cnt;
   logic [2:0]     bit_idx;
   logic [1:0]     byte_idx;
   logic [7:0]     shreg;
   logic [31:0]    word_asm;

`ifdef UART_RX_TIMEOUT_EN
   localparam int unsigned TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
   localparam int unsigned TOW      = $clog2(TO_LIMIT + 1);
   localparam logic [TOW-1:0] TO_LAST = TOW'(TO_LIMIT - 1);
   logic [TOW-1:0] to_cnt;
`endif

   uart_rx_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (rx),
      .q    (rx_s)
   );

   assign rx_busy = (state != ST_IDLE) || (byte_idx != '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         tick_cnt    <= '0;
         bit_idx     <= '0;
         byte_idx    <= '0;
         shreg       <= '0;
         word_asm    <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
         to_cnt      <= '0;
`endif
      end else begin
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         if (clken) begin
            case (state)
               ST_IDLE: begin
                  if (!rx_s) begin
                     state    <= ST_START;
                     tick_cnt <= '0;
`ifdef UART_RX_TIMEOUT_EN
                     to_cnt   <= '0;
`endif
                  end
`ifdef UART_RX_TIMEOUT_EN
                  else if (byte_idx != '0) begin
                     if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        byte_idx    <= '0;
                        to_cnt      <= '0;
                     end else begin
                        to_cnt <= to_cnt + 1'b1;
                     end
                  end
`endif
               end
               ST_START: begin
                  if (tick_cnt == HALF_LAST) begin
                     // A line already back high at mid start bit is a glitch.
                     if (rx_s) begin
                        state <= ST_IDLE;
                     end else begin
                        state    <= ST_DATA;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  if (tick_cnt == FULL_LAST) begin
                     tick_cnt        <= '0;
                     shreg[bit_idx]  <= rx_s;
                     if (bit_idx == 3'd7) begin
                        state <= ST_STOP;
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               ST_STOP: begin
                  if (tick_cnt == FULL_LAST) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        word_asm <= lane_write(word_asm, byte_idx, shreg);
                        if (byte_idx == 2'd3) begin
                           data_out   <= lane_write(word_asm, 2'd3, shreg);
                           data_valid <= 1'b1;
                           byte_idx   <= '0;
                        end else begin
                           byte_idx <= byte_idx + 1'b1;
                        end
                        // Leaving at mid stop bit allows back-to-back bytes.
                        state <= ST_IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        byte_idx  <= '0;
                        state     <= ST_BREAK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               ST_BREAK: begin
                  if (rx_s) begin
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
